// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: ping-pong frame buffer that launches one FFT per full frame
module fft_frame_scheduler #(
  parameter int DW = 16,
  parameter int N = 16,
  parameter int FRAMES = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        fir_valid_i,
  input  logic [DW-1:0]               fir_d_i,
  input  logic                        fft_busy_i,
  input  logic                        fft_done_i,
  input  logic [$clog2(N)-1:0]        fft_rd_addr_i,
  output logic [DW-1:0]               fft_rd_data_o,
  output logic                        fft_start_o,
  output logic                        fft_bank_o,
  output logic [$clog2(FRAMES+1)-1:0] frame_cnt_o,
  output logic                        overflow_o,
  output logic                        all_done_o
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(FRAMES+1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] mem_q [2*N];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] full_q, full_d, full_rel;
  logic wb_q, wb_d, rb_q, rb_d, bank_q, bank_d, start_q, start_d, ovf_q, ovf_d;
  logic rel, wr_en, wr_last, active;
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    bank_d = bank_q;
    rel = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    case (state_q)
      IDLE: if (full_q[rb_q] && !fft_busy_i) begin
        start_d = 1'b1;
        bank_d = rb_q;
        state_d = RUN;
      end
      RUN: if (fft_done_i) begin
        rel = 1'b1;
        state_d = (cnt_inc == CW'(FRAMES)) ? DONE : IDLE;
      end
      default: state_d = DONE;
    endcase
  end
  // a bank released this cycle is already free for an incoming write
  assign full_rel = rel ? (full_q & ~(rb_q ? 2'b10 : 2'b01)) : full_q;
  assign active = fir_valid_i && state_q != DONE;
  assign wr_en = active && !full_rel[wb_q];
  assign wr_last = wr_en && wr_ptr_q == AW'(N-1);
  always_comb begin
    full_d = full_rel | (wr_last ? (wb_q ? 2'b10 : 2'b01) : 2'b00);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    wb_d = wb_q ^ wr_last;
    rb_d = rb_q ^ rel;
    cnt_d = rel ? cnt_inc : cnt_q;
    ovf_d = ovf_q | (active && full_rel[wb_q]);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      full_q <= '0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      bank_q <= 1'b0;
      start_q <= 1'b0;
      ovf_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      bank_q <= bank_d;
      start_q <= start_d;
      ovf_q <= ovf_d;
      rd_q <= mem_q[{bank_q, fft_rd_addr_i}];
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[{wb_q, wr_ptr_q}] <= fir_d_i;
  end
  assign fft_rd_data_o = rd_q;
  assign fft_start_o = start_q;
  assign fft_bank_o = bank_q;
  assign frame_cnt_o = cnt_q;
  assign overflow_o = ovf_q;
  assign all_done_o = state_q == DONE;
endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sits between the FIR output stream and the 16-point FFT engine inside FAS. Collects FIR samples into a two-bank ping-pong frame buffer and launches one FFT per full 16-sample frame via a start/done handshake. Serves the engine's sample reads from the bank under transform, and raises `all_done` once the configured number of frames has been transformed. Reports dropped samples when both banks are occupied.

## Interface
- `DW`, 16, sample width (FIR output format, 8.8 fixed point)
- `N`, 16, samples per frame; power of two
- `FRAMES`, 64, frames per run (1024 samples / 16)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-low reset
- `fir_valid`  input  1  FIR sample strobe, one sample per high cycle
- `fir_d`  input  DW  FIR sample
- `fft_busy`  input  1  FFT engine cannot accept a start
- `fft_done`  input  1  one-cycle pulse: engine has finished the current frame
- `fft_rd_addr`  input  log2(N)  sample index the engine reads
- `fft_rd_data`  output  DW  sample at `fft_rd_addr` in bank `fft_bank`, registered
- `fft_start`  output  1  one-cycle launch pulse
- `fft_bank`  output  1  bank under transform
- `frame_cnt`  output  $clog2(FRAMES+1)  completed frames
- `overflow`  output  1  sticky: at least one sample dropped
- `all_done`  output  1  sticky: `FRAMES` frames completed

## Operation
- Storage: `bank[2][N]` of DW bits, a write pointer `wr_ptr` (log2 N), a write bank `wb`, a read bank `rb`, and per-bank `full[1:0]` flags.
- Write path:
  - When `fir_valid` is high and `full[wb]` is 0, store `fir_d` at `bank[wb][wr_ptr]` and increment `wr_ptr`.
  - On the write at `wr_ptr == N-1`: set `full[wb]`, toggle `wb`, and wrap `wr_ptr` to 0.
- Drop: `fir_valid` while `full[wb]` is 1 discards the sample. `wr_ptr` does not advance and `overflow` is set.
- FSM states are IDLE, RUN and DONE.
  - IDLE: when `full[rb]` is 1 and `fft_busy` is 0, drive `fft_start` high for one cycle, set `fft_bank = rb`, and go to RUN. Otherwise stay in IDLE.
  - RUN: on `fft_done`, clear `full[rb]`, toggle `rb`, and increment `frame_cnt`. If the new count equals `FRAMES`, go to DONE; otherwise go to IDLE.
  - DONE: assert `all_done`. Ignore `fir_valid`, `fft_done` and `fft_busy`. Exit only through reset.
- `fft_done` is ignored outside RUN.
- Banks are always processed in fill order (0, 1, 0, ...).
- `fft_bank` holds its value from the start pulse until the next start.
- `fft_rd_data <= bank[fft_bank][fft_rd_addr]` every cycle, in every state.
- Same-cycle release and write: if `fft_done` clears `full[b]` in the same cycle that `fir_valid` targets bank b, the write is accepted. The free check uses the post-release value.
- Writing the last sample and receiving `fft_done` in the same cycle: both updates take effect; the `full` flags are independent.

## Timing
- Reset (`rst` low at a rising edge) forces:
  - outputs: `fft_start` = 0, `fft_bank` = 0, `fft_rd_data` = 0, `frame_cnt` = 0, `overflow` = 0, `all_done` = 0;
  - internal state: `wr_ptr` = 0, `wb` = 0, `rb` = 0, `full` = 00, FSM = IDLE.
- Buffer contents are not reset.
- Reset mid-frame or mid-FFT discards the partial or pending frames. Any later `fft_done` arrives in IDLE and is ignored.
- Start latency: edge E writes sample N-1. `fft_start` is high between E+1 and E+2, provided `fft_busy` is 0 at E+1. Each cycle `fft_busy` stays high adds one cycle of delay.
- `fft_rd_data` has a latency of 1 cycle from `fft_rd_addr`.
- The earliest next start is the edge after the `fft_done` edge, if the other bank is already full.
- Sustained throughput: no drops as long as each FFT (start to done) finishes within N sample cycles.

## Test plan
- Reset: hold `rst` low for 2 cycles, then release with no stimulus. All outputs stay at their reset values for 20 cycles.
- Single frame: drive 16 consecutive `fir_valid` with data 0x0100..0x010F.
  - `fft_start` pulses exactly one cycle, one edge after the 16th write, with `fft_bank` = 0.
  - `fft_rd_addr` = 5 returns 0x0105 on the next cycle.
  - `fft_done` then gives `frame_cnt` = 1.
- Busy stall: fill a frame while `fft_busy` = 1 for 10 cycles. `fft_start` fires one edge after `fft_busy` falls, and only once.
- Overflow: 40 samples with no `fft_done`.
  - Samples 33..40 are dropped and `overflow` = 1.
  - After `fft_done`, the next sample 0x0AAA is stored at bank 0 index 0.
  - A second `fft_start` is issued with `fft_bank` = 1.
- Simultaneous release and write:
  - Setup: both banks full, FSM in RUN on bank 0.
  - Stimulus: `fft_done` and `fir_valid` (0x1234) in the same cycle.
  - Required: the sample is accepted into bank 0 index 0 and `overflow` stays 0.
- Full run with `FRAMES` = 64:
  - Stimulus: 1024 samples, `fft_done` 5 cycles after each start.
  - Required: `all_done` = 1 and `frame_cnt` = 64. No further `fft_start` occurs despite extra samples.
  - Then reset in the middle of frame 10 of a second run: `frame_cnt` returns to 0 and bank 0 refills from index 0.
